// File: rtl/pad_ctrl_pkg.sv
// ------------------------------------------------------------
// pad_ctrl_pkg: shared types and constants for the pad-control bank.
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SAFE = 2'd0,
    MODE_CORE = 2'd1,
    MODE_GPIO = 2'd2
  } pad_mode_t;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FREEZE = 2'd2
  } seq_state_t;

  // Bit layout of the per-pad configuration byte, MSB first.
  typedef struct packed {
    logic       gpio_oe;
    logic       gpio_out;
    logic       pd;
    logic       pu;
    logic       sl;
    logic       cs;
    logic [1:0] mode;
  } pad_cfg_t;

  localparam pad_cfg_t CFG_RESET = '0;

  localparam logic SAFE_A  = 1'b0;
  localparam logic SAFE_OE = 1'b0;
  localparam logic SAFE_IE = 1'b1;
  localparam logic SAFE_PU = 1'b0;
  localparam logic SAFE_PD = 1'b1;
  localparam logic SAFE_CS = 1'b0;
  localparam logic SAFE_SL = 1'b0;

  localparam logic [6:0] INPUT_BASE = 7'h40;

endpackage

`default_nettype wire

// File: rtl/pad_sync.sv
// ------------------------------------------------------------
// pad_sync: multi-stage synchroniser for pad-to-core inputs.
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

  assign q = stages[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pad_ctrl_bank.sv
// ------------------------------------------------------------
// pad_ctrl_bank: per-pad mode registers, release sequencer and freeze.
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module pad_ctrl_bank
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 40,
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_req,
  input  logic                      cfg_we,
  input  logic [6:0]                cfg_addr,
  input  logic [7:0]                cfg_wdata,
  output logic                      cfg_ack,
  output logic [7:0]                cfg_rdata,
  input  logic                      freeze_req,
  output logic [1:0]                state_o,
  input  logic [NUM_BIDIR_PADS-1:0] core_out,
  input  logic [NUM_BIDIR_PADS-1:0] core_oe,
  input  logic [NUM_BIDIR_PADS-1:0] core_cs,
  input  logic [NUM_BIDIR_PADS-1:0] core_sl,
  input  logic [NUM_BIDIR_PADS-1:0] core_pu,
  input  logic [NUM_BIDIR_PADS-1:0] core_pd,
  output logic [NUM_BIDIR_PADS-1:0] core_in,
  output logic [NUM_BIDIR_PADS-1:0] pad_a,
  output logic [NUM_BIDIR_PADS-1:0] pad_oe,
  output logic [NUM_BIDIR_PADS-1:0] pad_cs,
  output logic [NUM_BIDIR_PADS-1:0] pad_sl,
  output logic [NUM_BIDIR_PADS-1:0] pad_ie,
  output logic [NUM_BIDIR_PADS-1:0] pad_pu,
  output logic [NUM_BIDIR_PADS-1:0] pad_pd,
  input  logic [NUM_BIDIR_PADS-1:0] pad_y
);

  localparam int NUM_IN_BYTES = (NUM_BIDIR_PADS + 7) / 8;
  localparam int CNT_W        = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  pad_cfg_t   cfg_regs [NUM_BIDIR_PADS];
  seq_state_t state;
  logic [CNT_W-1:0] hold_cnt;

  logic [7:0]                    rd_val;
  logic [NUM_IN_BYTES*8-1:0]     in_bytes;
  logic [NUM_BIDIR_PADS-1:0]     mux_a, mux_oe, mux_cs, mux_sl, mux_ie, mux_pu, mux_pd;

  pad_sync #(
    .WIDTH  (NUM_BIDIR_PADS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_y),
    .q   (core_in)
  );

  // Read decode: config bytes at 0..N-1, synchronised input bytes at INPUT_BASE+k.
  always_comb begin
    rd_val   = 8'h00;
    in_bytes = '0;
    in_bytes[NUM_BIDIR_PADS-1:0] = core_in;
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      if (cfg_addr == 7'(i)) rd_val = cfg_regs[i];
    end
    for (int k = 0; k < NUM_IN_BYTES; k++) begin
      if (cfg_addr == INPUT_BASE + 7'(k)) rd_val = in_bytes[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BIDIR_PADS; i++) cfg_regs[i] <= CFG_RESET;
      cfg_ack   <= 1'b0;
      cfg_rdata <= 8'h00;
    end else begin
      cfg_ack   <= cfg_req;
      cfg_rdata <= cfg_req ? rd_val : 8'h00;
      if (cfg_req && cfg_we) begin
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
          if (cfg_addr == 7'(i)) cfg_regs[i] <= pad_cfg_t'(cfg_wdata);
        end
      end
    end
  end

  always_comb begin
    mux_a  = '0;
    mux_oe = '0;
    mux_cs = '0;
    mux_sl = '0;
    mux_ie = '0;
    mux_pu = '0;
    mux_pd = '0;
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      mux_a[i]  = SAFE_A;
      mux_oe[i] = SAFE_OE;
      mux_cs[i] = SAFE_CS;
      mux_sl[i] = SAFE_SL;
      mux_ie[i] = SAFE_IE;
      mux_pu[i] = SAFE_PU;
      mux_pd[i] = SAFE_PD;
      case (cfg_regs[i].mode)
        MODE_CORE: begin
          mux_a[i]  = core_out[i];
          mux_oe[i] = core_oe[i];
          mux_cs[i] = core_cs[i];
          mux_sl[i] = core_sl[i];
          mux_pu[i] = core_pu[i];
          mux_pd[i] = core_pd[i];
        end
        MODE_GPIO: begin
          mux_a[i]  = cfg_regs[i].gpio_out;
          mux_oe[i] = cfg_regs[i].gpio_oe;
          mux_cs[i] = cfg_regs[i].cs;
          mux_sl[i] = cfg_regs[i].sl;
          mux_pu[i] = cfg_regs[i].pu;
          mux_pd[i] = cfg_regs[i].pd;
        end
        default: ;
      endcase
    end
  end

  // Pad flops are frozen in FREEZE and forced SAFE while HOLD runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      pad_a    <= {NUM_BIDIR_PADS{SAFE_A}};
      pad_oe   <= {NUM_BIDIR_PADS{SAFE_OE}};
      pad_cs   <= {NUM_BIDIR_PADS{SAFE_CS}};
      pad_sl   <= {NUM_BIDIR_PADS{SAFE_SL}};
      pad_ie   <= {NUM_BIDIR_PADS{SAFE_IE}};
      pad_pu   <= {NUM_BIDIR_PADS{SAFE_PU}};
      pad_pd   <= {NUM_BIDIR_PADS{SAFE_PD}};
    end else begin
      case (state)
        ST_HOLD: begin
          pad_a  <= {NUM_BIDIR_PADS{SAFE_A}};
          pad_oe <= {NUM_BIDIR_PADS{SAFE_OE}};
          pad_cs <= {NUM_BIDIR_PADS{SAFE_CS}};
          pad_sl <= {NUM_BIDIR_PADS{SAFE_SL}};
          pad_ie <= {NUM_BIDIR_PADS{SAFE_IE}};
          pad_pu <= {NUM_BIDIR_PADS{SAFE_PU}};
          pad_pd <= {NUM_BIDIR_PADS{SAFE_PD}};
          if (hold_cnt == CNT_LAST) state    <= ST_ACTIVE;
          else                      hold_cnt <= hold_cnt + 1'b1;
        end
        ST_ACTIVE: begin
          pad_a  <= mux_a;
          pad_oe <= mux_oe;
          pad_cs <= mux_cs;
          pad_sl <= mux_sl;
          pad_ie <= mux_ie;
          pad_pu <= mux_pu;
          pad_pd <= mux_pd;
          if (freeze_req) state <= ST_FREEZE;
        end
        ST_FREEZE: begin
          if (!freeze_req) state <= ST_ACTIVE;
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: doc/pad_ctrl_bank.md
Name: pad_ctrl_bank

Overview:
- Parametrised pad-control layer between chip_core and the bidirectional pad ring.
- Replaces direct core-to-pad wiring of OE/CS/SL/IE/PU/PD.
- Adds per-pad mode registers (SAFE/CORE/GPIO), a post-reset release sequencer, a freeze mode and input synchronisers.
- Configured through a simple single-cycle register request/acknowledge port driven by the core.

Parameters:
- NUM_BIDIR_PADS, 40, number of bidirectional pads handled (1..64).
- SYNC_STAGES, 2, flop stages on each pad-to-core input (2..4).
- RELEASE_CYCLES, 16, cycles that pads are held SAFE after reset before the block goes ACTIVE (≥1).

Ports:
- clk  in  1  core clock (from clk pad).
- rst  in  1  synchronous, active-high reset.
- cfg_req  in  1  register access request, single-cycle.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  7  register address.
- cfg_wdata  in  8  write data.
- cfg_ack  out  1  access completed.
- cfg_rdata  out  8  read data, valid with cfg_ack.
- freeze_req  in  1  level; hold all pad outputs at current values.
- state_o  out  2  sequencer state (0 HOLD, 1 ACTIVE, 2 FREEZE).
- core_out, core_oe, core_cs, core_sl, core_pu, core_pd  in  NUM_BIDIR_PADS each  core-requested pad controls.
- core_in  out  NUM_BIDIR_PADS  synchronised pad inputs.
- pad_a, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd  out  NUM_BIDIR_PADS each  to pad cells.
- pad_y  in  NUM_BIDIR_PADS  raw pad-cell Y.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All state changes happen on the rising edge of clk.
- Config register per pad i, at address i, 8 bits:
  - [1:0] mode: 0 SAFE, 1 CORE, 2 GPIO, 3 treated as SAFE.
  - [2] cs, [3] sl, [4] pu, [5] pd, [6] gpio_out, [7] gpio_oe.
  - Reset value 0x00.
- Input bytes at address 0x40+k, for k < ceil(N/8), are read-only. Bit j = synchronised input of pad 8k+j; bits for unused pads read 0.
- Any other address reads 0x00. Writes to it, or to 0x40+, are ignored but still acknowledged.
- Access handshake:
  - cfg_ack pulses exactly 1 cycle after each cycle with cfg_req=1.
  - cfg_rdata holds the pre-write register value on that cycle; it is 0 when ack=0.
  - Back-to-back requests give back-to-back acks.
  - A write takes effect on the pad outputs 2 cycles after the req cycle.
- Per-pad mux (computed combinationally, then registered):
  - SAFE: a=0, oe=0, ie=1, pu=0, pd=1, cs=0, sl=0.
  - CORE: a/oe/cs/sl/pu/pd taken from core_*, ie=1.
  - GPIO: a=gpio_out, oe=gpio_oe, cs/sl/pu/pd from the register, ie=1.
- All pad_* outputs are flopped: core_* to pad_* latency is 1 cycle.
- Sequencer FSM:
  - Reset → HOLD with counter=0. Every pad is forced to SAFE values regardless of its register.
  - HOLD: counter increments each cycle. When counter = RELEASE_CYCLES-1 → ACTIVE.
  - ACTIVE: outputs follow the mux. freeze_req=1 → FREEZE.
  - FREEZE: pad_* flops are not updated. Register accesses are still accepted and acked, with no output effect. freeze_req=0 → ACTIVE; outputs update on the next edge.
  - freeze_req during HOLD is ignored; HOLD always completes.
- Reset values: pad_* = SAFE values (pad_ie=all 1, pad_pd=all 1, all others 0); core_in=0; cfg_ack=0; cfg_rdata=0; state_o=0.
- rst asserted mid-operation, including during FREEZE: registers clear and the block returns to HOLD on that edge.
- Input path: pad_y → SYNC_STAGES flops → core_in. Latency is SYNC_STAGES cycles, in all states.
- Simultaneous events: a write to pad i on the same edge that HOLD→ACTIVE takes place is still applied; the pad shows the new value 2 cycles after req.

Decomposition:
- Package pad_ctrl_pkg holds:
  - mode enum (SAFE/CORE/GPIO).
  - sequencer state enum.
  - config bit-field struct and its reset constant.
  - SAFE-value constants.
  - INPUT_BASE = 7'h40.
- Sub-module pad_sync: per-bit SYNC_STAGES synchroniser, instantiated NUM_BIDIR_PADS wide.

Test Plan:
- Reset, then idle: pad_pd=all 1, pad_oe=0 for cycles 0..15; state_o=1 at cycle 16 (RELEASE_CYCLES=16). Core driving core_oe=1 during HOLD has no effect.
- After ACTIVE: write 0x01 to addr 3 with core_out[3]=1, core_oe[3]=1 → pad_a[3]=pad_oe[3]=1 two cycles after req; read addr 3 → cfg_rdata=0x01 one cycle later.
- GPIO mode: write 0xC2 to addr 5 → pad_a[5]=1, pad_oe[5]=1, pad_pd[5]=0. Write 0x32 → pad_pu[5]=1, pad_pd[5]=1, pad_oe[5]=0.
- Freeze: in ACTIVE set freeze_req, toggle core_out[3] and write 0x00 to addr 3 → pad_a[3] unchanged and ack still received. Deassert freeze_req → pad_oe[3]=0 next edge.
- Input: drive pad_y[9]=1 → core_in[9]=1 after exactly 2 cycles; read addr 0x41 → bit 1 set. Read addr 0x30 → 0x00 with ack.
- Reset during FREEZE: assert rst one cycle → state_o=0, all pad_* at SAFE values, addr 3 reads 0x00.
